ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
- Initiator for the single-port RAM (`ram1`). It owns the RAM's `addr` / `i_data` / `we` and reads its combinational `o_data`.
- Accepts burst commands (start address, length, direction) through a valid/ready command port.
- Write bursts move a valid/ready input stream into consecutive RAM words. Read bursts stream consecutive RAM words out through a valid/ready output port with backpressure.
- Sits between stream-side logic and the RAM instance.

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  ADDR_WIDTH  burst length minus 1 (0 = 1 word, DEPTH-1 = whole RAM).
- wr_data  in  DATA_WIDTH  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- rd_data  out  DATA_WIDTH  read stream data.
- rd_valid  out  1  read stream valid.
- rd_ready  in  1  read beat consumed when rd_valid && rd_ready.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final beat of a burst.
- mem_addr  out  ADDR_WIDTH  to RAM `addr`.
- mem_wdata  out  DATA_WIDTH  to RAM `i_data`.
- mem_we  out  1  to RAM `we`.
- mem_rdata  in  DATA_WIDTH  from RAM `o_data` (combinational read of mem_addr).

Behaviour:
- State machine states are IDLE, WR and RD. Registers: state, addr_reg, cnt_reg, done.
- Reset (asynchronous, immediate):
  - state=IDLE, addr_reg=0, cnt_reg=0, done=0.
  - Outputs therefore: cmd_ready=1, busy=0, wr_ready=0, rd_valid=0, mem_we=0, mem_addr=0.
- IDLE:
  - cmd_ready=1.
  - On command accept: addr_reg<=cmd_addr, cnt_reg<=cmd_len, state<=WR if cmd_write else RD.
  - First beat is possible in the following cycle.
- WR state:
  - wr_ready=1; mem_addr=addr_reg; mem_wdata=wr_data; mem_we=wr_valid (combinational). The RAM captures the word on the same clock edge as the beat.
  - On each beat: addr_reg<=addr_reg+1, modulo DEPTH (wraps DEPTH-1 -> 0).
  - If cnt_reg==0, state<=IDLE and done<=1; otherwise cnt_reg<=cnt_reg-1.
  - No beat, no change.
- RD state:
  - rd_valid=1; mem_addr=addr_reg; rd_data=mem_rdata; mem_we=0.
  - Zero-cycle read latency: data is valid in the same cycle mem_addr is driven.
  - While rd_ready=0, addr_reg is held, so rd_data stays stable.
  - On a beat, addr_reg and cnt_reg advance exactly as in WR; after the final beat, go to IDLE with done<=1.
- Outputs outside the active state:
  - wr_ready=0 outside WR; rd_valid=0 outside RD; mem_we=0 outside WR.
  - mem_wdata=wr_data at all times.
- busy = (state != IDLE).
- done:
  - High for exactly the one cycle after the last beat; that cycle is already IDLE with cmd_ready=1.
  - A new command may be accepted in the done cycle (back-to-back bursts, one idle cycle between the last and first beats).
  - Otherwise done=0.
- Wrap-around: a burst crossing DEPTH-1 continues at 0. A burst with cmd_len=DEPTH-1 touches every word exactly once.
- Input streams outside their state: wr_valid in IDLE/RD and rd_ready in IDLE/WR are ignored, with no RAM write.
- Reset mid-burst: returns to IDLE at once and remaining beats are abandoned. Words already written stay in the RAM; the controller does not clear RAM contents.
- Width rules: all address and count arithmetic is ADDR_WIDTH wide and unsigned, with natural wrap and no saturation.

Test Plan:
- Reset check: assert rst with clk stopped -> cmd_ready=1, busy=0, done=0, mem_we=0, wr_ready=0, rd_valid=0, mem_addr=0.
- Gapped write burst:
  - Stimulus: write cmd addr=3 len=3, then data 0xA1, 0xA2, 0xA3, 0xA4 with wr_valid low every other cycle.
  - Required: RAM[3..6]=A1..A4; mem_we high only on beat cycles; done pulses once, the cycle after the 0xA4 beat; busy low in that cycle.
- Backpressured read burst:
  - Stimulus: read cmd addr=3 len=3 with rd_ready pattern 1,0,0,1,1,0,1.
  - Required: rd_data sequence A1, A2, A3, A4; rd_data and mem_addr unchanged during stalls; exactly 4 beats, then done.
- Wrap-around:
  - Stimulus: write cmd addr=14 len=3 with 0x10..0x13, then read cmd addr=14 len=3.
  - Required: RAM[14]=10, RAM[15]=11, RAM[0]=12, RAM[1]=13; the read returns the same order.
- Full depth plus back-to-back:
  - Stimulus: write cmd addr=0 len=15 with data=address value; issue the read cmd addr=0 len=15 in the done cycle.
  - Required: it is accepted in that cycle; the read returns 0x00..0x0F.
- Reset mid-burst:
  - Stimulus: write cmd addr=8 len=5; assert rst after 2 beats (0x55, 0x66) while wr_valid is held high.
  - Required: only RAM[8]=55 and RAM[9]=66 are written; mem_we drops immediately; no done pulse; cmd_ready=1 afterwards.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port RAM with a combinational read port.
// A command (start address, length-1, direction) is taken while idle; the
// controller then moves one word per stream handshake: write beats go from
// the wr_* stream into the RAM, read beats come from the RAM onto rd_*.
// Addresses wrap modulo the RAM depth.
module ram_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  cmd_acc;
  logic                  beat;
  logic                  last;

  // Handshake qualifiers: a beat is only meaningful in the matching state,
  // so stray wr_valid / rd_ready outside their burst are ignored.
  assign cmd_acc = cmd_valid && (state == IDLE);
  assign beat    = ((state == WR) && wr_valid) || ((state == RD) && rd_ready);
  assign last    = (cnt_reg == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Address / remaining-count tracking and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_acc) begin
        addr_reg <= cmd_addr;
        cnt_reg  <= cmd_len;
      end else if (beat) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        if (last) begin
          done <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Next-state: leave a burst on the beat that consumes the last word.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nxt = cmd_write ? WR : RD;
      WR:   if (wr_valid && last) state_nxt = IDLE;
      RD:   if (rd_ready && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: RAM is driven straight from addr_reg so reads have zero latency
  // and a stalled read keeps presenting the same word.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    wr_ready  = (state == WR);
    rd_valid  = (state == RD);
    mem_we    = (state == WR) && wr_valid;
    mem_addr  = addr_reg;
    mem_wdata = wr_data;
    rd_data   = mem_rdata;
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: a behavioural RAM sits on the mem_* port and a
// reference word array is updated from the burst rules (start + beat index,
// modulo depth) to predict RAM contents and read-stream data.
module tb_ram_burst_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  bit            clk_en = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Single-port RAM with combinational read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_vld [DEPTH];

  int total = 0;
  int bad   = 0;

  // Observations gathered by the burst drivers.
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] rd_q[$];
  int            rdy_pat[$];
  int            beats, we_err, addr_err, done_early, stall_err, vld_err;
  bit            timeout;
  logic          acc;

  // Present a command for one cycle; called at posedge+1, returns at posedge+1.
  task automatic send_cmd(input logic w, input int a, input int l);
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_len   = AW'(l);
    cmd_valid = 1'b1;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Drive a write stream from wr_q. mode 0: always valid, 1: valid every
  // other cycle, 2: random valid. Stray rd_ready is toggled throughout.
  task automatic run_write(input int a, input int l, input int mode);
    int idx = 0;
    int cyc = 0;
    we_err = 0; addr_err = 0; done_early = 0; timeout = 0;
    while (idx <= l) begin
      if (cyc > 300) begin
        timeout = 1;
        break;
      end
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (cyc % 2 == 0);
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      wr_data  = wr_q[idx];
      rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_we !== wr_valid) we_err++;
      if (done !== 1'b0) done_early++;
      if (wr_valid && wr_ready === 1'b1) begin
        if (mem_addr !== AW'((a + idx) % DEPTH)) addr_err++;
        ref_mem[(a + idx) % DEPTH] = wr_q[idx];
        ref_vld[(a + idx) % DEPTH] = 1'b1;
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    beats = idx;
  endtask

  // Consume a read stream into rd_q. mode 0: rd_ready from rdy_pat, 1: random.
  // Stray wr_valid with junk data is driven throughout.
  task automatic run_read(input int a, input int l, input int mode);
    int            idx = 0;
    int            cyc = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;
    we_err = 0; addr_err = 0; done_early = 0; stall_err = 0; vld_err = 0;
    timeout = 0;
    rd_q.delete();
    while (idx <= l) begin
      if (cyc > 300) begin
        timeout = 1;
        break;
      end
      rd_ready = (mode == 0) ? 1'(rdy_pat[cyc % rdy_pat.size()]) : 1'($urandom_range(0, 1));
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = DW'($urandom);
      @(negedge clk);
      if (mem_we !== 1'b0) we_err++;
      if (done !== 1'b0) done_early++;
      if (rd_valid !== 1'b1) vld_err++;
      if (prev_stall && (rd_data !== prev_d || mem_addr !== prev_a)) stall_err++;
      if (rd_valid === 1'b1 && rd_ready) begin
        if (mem_addr !== AW'((a + idx) % DEPTH)) addr_err++;
        rd_q.push_back(rd_data);
        idx++;
        prev_stall = 0;
      end else begin
        prev_stall = (rd_valid === 1'b1);
        prev_d = rd_data;
        prev_a = mem_addr;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    beats = idx;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #3;
    total += 7;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    if (mem_we !== 1'b0)    begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    if (wr_ready !== 1'b0)  begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    if (mem_addr !== '0)    begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_gapped_write();
    send_cmd(1'b1, 3, 3);
    wr_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL gw_cmd_accept got=%b exp=1", acc); end
    run_write(3, 3, 1);
    total += 5;
    if (timeout)         begin bad++; $display("FAIL gw_timeout got=%0d beats exp=4", beats); end
    if (beats != 4)      begin bad++; $display("FAIL gw_beats got=%0d exp=4", beats); end
    if (we_err != 0)     begin bad++; $display("FAIL gw_mem_we got=%0d bad cycles exp=0", we_err); end
    if (addr_err != 0)   begin bad++; $display("FAIL gw_mem_addr got=%0d bad beats exp=0", addr_err); end
    if (done_early != 0) begin bad++; $display("FAIL gw_done_early got=%0d exp=0", done_early); end
    @(negedge clk);
    total += 3;
    if (done !== 1'b1)      begin bad++; $display("FAIL gw_done_pulse got=%b exp=1", done); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL gw_busy_in_done got=%b exp=0", busy); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL gw_cmd_ready_in_done got=%b exp=1", cmd_ready); end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL gw_done_once got=%b exp=0", done); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ram[3 + i] !== wr_q[i]) begin bad++; $display("FAIL gw_ram%0d got=%0h exp=%0h", 3 + i, ram[3 + i], wr_q[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_backpressure();
    logic [DW-1:0] exp_d;
    send_cmd(1'b0, 3, 3);
    rdy_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_read(3, 3, 0);
    total += 6;
    if (timeout)         begin bad++; $display("FAIL rb_timeout got=%0d beats exp=4", beats); end
    if (rd_q.size() != 4) begin bad++; $display("FAIL rb_beats got=%0d exp=4", rd_q.size()); end
    if (stall_err != 0)  begin bad++; $display("FAIL rb_stall_stable got=%0d bad exp=0", stall_err); end
    if (addr_err != 0)   begin bad++; $display("FAIL rb_mem_addr got=%0d bad exp=0", addr_err); end
    if (we_err != 0)     begin bad++; $display("FAIL rb_mem_we got=%0d bad exp=0", we_err); end
    if (vld_err != 0)    begin bad++; $display("FAIL rb_rd_valid got=%0d bad exp=0", vld_err); end
    for (int i = 0; i < rd_q.size(); i++) begin
      exp_d = DW'(8'hA1 + i);
      total++;
      if (rd_q[i] !== exp_d) begin bad++; $display("FAIL rb_data%0d got=%0h exp=%0h", i, rd_q[i], exp_d); end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL rb_done got=%b exp=1", done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_w [4];
    exp_w = '{8'h10, 8'h11, 8'h12, 8'h13};
    wr_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_cmd(1'b1, 14, 3);
    run_write(14, 3, 0);
    total += 5;
    if (timeout || beats != 4) begin bad++; $display("FAIL wrap_wr_beats got=%0d exp=4", beats); end
    if (ram[14] !== exp_w[0]) begin bad++; $display("FAIL wrap_ram14 got=%0h exp=%0h", ram[14], exp_w[0]); end
    if (ram[15] !== exp_w[1]) begin bad++; $display("FAIL wrap_ram15 got=%0h exp=%0h", ram[15], exp_w[1]); end
    if (ram[0] !== exp_w[2])  begin bad++; $display("FAIL wrap_ram0 got=%0h exp=%0h", ram[0], exp_w[2]); end
    if (ram[1] !== exp_w[3])  begin bad++; $display("FAIL wrap_ram1 got=%0h exp=%0h", ram[1], exp_w[3]); end
    @(posedge clk);
    #1;
    send_cmd(1'b0, 14, 3);
    run_read(14, 3, 1);
    total += 2;
    if (timeout || rd_q.size() != 4) begin bad++; $display("FAIL wrap_rd_beats got=%0d exp=4", rd_q.size()); end
    if (addr_err != 0) begin bad++; $display("FAIL wrap_rd_addr got=%0d bad exp=0", addr_err); end
    for (int i = 0; i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== exp_w[i]) begin bad++; $display("FAIL wrap_rd%0d got=%0h exp=%0h", i, rd_q[i], exp_w[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    wr_q.delete();
    for (int i = 0; i < DEPTH; i++) wr_q.push_back(DW'(i));
    send_cmd(1'b1, 0, DEPTH - 1);
    run_write(0, DEPTH - 1, 2);
    total += 2;
    if (timeout || beats != DEPTH) begin bad++; $display("FAIL b2b_wr_beats got=%0d exp=%0d", beats, DEPTH); end
    if (we_err != 0) begin bad++; $display("FAIL b2b_mem_we got=%0d bad exp=0", we_err); end
    // Issue the read in the done cycle.
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = AW'(DEPTH - 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    total += 2;
    if (done !== 1'b1)      begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_rd_started got=%b exp=1", rd_valid); end
    @(posedge clk);
    #1;
    run_read(0, DEPTH - 1, 1);
    total++;
    if (timeout || rd_q.size() != DEPTH) begin bad++; $display("FAIL b2b_rd_beats got=%0d exp=%0d", rd_q.size(), DEPTH); end
    for (int i = 0; i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== DW'(i)) begin bad++; $display("FAIL b2b_rd%0d got=%0h exp=%0h", i, rd_q[i], i); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 8, 5);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("FAIL rm_beat1_we got=%b exp=1", mem_we); end
    @(posedge clk);
    #1;
    wr_data = 8'h66;
    @(negedge clk);
    total++;
    if (mem_addr !== AW'(9)) begin bad++; $display("FAIL rm_beat2_addr got=%0h exp=9", mem_addr); end
    @(posedge clk);
    #1;
    ref_mem[8] = 8'h55; ref_vld[8] = 1'b1;
    ref_mem[9] = 8'h66; ref_vld[9] = 1'b1;
    wr_data = 8'h77;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total += 4;
    if (mem_we !== 1'b0)    begin bad++; $display("FAIL rm_we_drop got=%b exp=0", mem_we); end
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_cmd_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    if (wr_ready !== 1'b0)  begin bad++; $display("FAIL rm_wr_ready got=%b exp=0", wr_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL rm_idle_we got=%b exp=0", mem_we); end
    if (done !== 1'b0)   begin bad++; $display("FAIL rm_no_done got=%b exp=0", done); end
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    total += 4;
    if (done !== 1'b0)     begin bad++; $display("FAIL rm_no_done2 got=%b exp=0", done); end
    if (ram[8] !== 8'h55)  begin bad++; $display("FAIL rm_ram8 got=%0h exp=55", ram[8]); end
    if (ram[9] !== 8'h66)  begin bad++; $display("FAIL rm_ram9 got=%0h exp=66", ram[9]); end
    if (ram[10] !== 8'h0A) begin bad++; $display("FAIL rm_ram10 got=%0h exp=0a", ram[10]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_bursts();
    int a, l;
    for (int n = 0; n < 8; n++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH - 1);
      wr_q.delete();
      for (int i = 0; i <= l; i++) wr_q.push_back(DW'($urandom));
      send_cmd(1'b1, a, l);
      run_write(a, l, 2);
      total += 2;
      if (timeout || beats != l + 1) begin bad++; $display("FAIL rnd%0d_wr_beats got=%0d exp=%0d", n, beats, l + 1); end
      if (we_err != 0 || addr_err != 0) begin bad++; $display("FAIL rnd%0d_wr_port got=%0d/%0d exp=0/0", n, we_err, addr_err); end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL rnd%0d_wr_done got=%b exp=1", n, done); end
      @(posedge clk);
      #1;
      send_cmd(1'b0, a, l);
      run_read(a, l, 1);
      total += 2;
      if (timeout || rd_q.size() != l + 1) begin bad++; $display("FAIL rnd%0d_rd_beats got=%0d exp=%0d", n, rd_q.size(), l + 1); end
      if (stall_err != 0 || we_err != 0) begin bad++; $display("FAIL rnd%0d_rd_port got=%0d/%0d exp=0/0", n, stall_err, we_err); end
      for (int i = 0; i < rd_q.size(); i++) begin
        total++;
        if (rd_q[i] !== ref_mem[(a + i) % DEPTH]) begin
          bad++;
          $display("FAIL rnd%0d_rd%0d got=%0h exp=%0h", n, i, rd_q[i], ref_mem[(a + i) % DEPTH]);
        end
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL rnd%0d_rd_done got=%b exp=1", n, done); end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ref_vld[i]) begin
        total++;
        if (ram[i] !== ref_mem[i]) begin bad++; $display("FAIL final_ram%0d got=%0h exp=%0h", i, ram[i], ref_mem[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      ref_vld[i] = 1'b0;
    end
    test_reset();
    test_gapped_write();
    test_read_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
